// File: rtl/dm_cache_fsm_block.sv
// Direct-mapped, write-back, write-allocate cache controller.
//
// cache_def: request/response struct types shared with the surrounding system.
//
// dm_cache_fsm_block
//   Parameter CACHE_BLOCKS : number of one-word lines (power of two, >= 2).
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous, active-high reset
//   cpu_req  in   processor request (rw=1 write), sampled only in IDLE
//   mem_data in   memory response, ready is a one-cycle completion pulse
//   mem_req  out  registered memory request (write-back or line fill)
//   cpu_res  out  registered lookup result (checked / ready pulses)

package cache_def;
  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } mem_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } mem_data_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
    logic        checked;
  } cpu_result_type;
endpackage

module dm_cache_fsm_block
  import cache_def::*;
#(
  parameter int CACHE_BLOCKS = 128
) (
  input  logic           clk,
  input  logic           rst,
  input  cpu_req_type    cpu_req,
  input  mem_data_type   mem_data,
  output mem_req_type    mem_req,
  output cpu_result_type cpu_res
);

  localparam int IDX_W = $clog2(CACHE_BLOCKS);
  localparam int TAG_W = 14 - IDX_W;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COMPARE_TAG = 2'd1,
    WRITE_BACK  = 2'd2,
    ALLOCATE    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  cpu_req_type             req_q, req_d;
  mem_req_type             mem_req_q, mem_req_d;
  cpu_result_type          cpu_res_q, cpu_res_d;
  logic [CACHE_BLOCKS-1:0] valid_q, valid_d;
  logic [CACHE_BLOCKS-1:0] dirty_q, dirty_d;

  // Tag and data storage carry no reset; valid/dirty alone decide whether a
  // line means anything.
  logic [TAG_W-1:0] tag_mem  [CACHE_BLOCKS];
  logic [31:0]      data_mem [CACHE_BLOCKS];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] cur_tag;
  logic [31:0]      cur_data;
  logic             hit;
  logic             line_we;
  logic [31:0]      line_wdata;

  assign req_idx  = req_q.addr[IDX_W+1:2];
  assign req_tag  = req_q.addr[15:IDX_W+2];
  assign cur_tag  = tag_mem[req_idx];
  assign cur_data = data_mem[req_idx];
  assign hit      = valid_q[req_idx] && (cur_tag == req_tag);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    mem_req_d  = mem_req_q;
    cpu_res_d  = cpu_res_q;
    cpu_res_d.ready   = 1'b0;
    cpu_res_d.checked = 1'b0;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    line_we    = 1'b0;
    line_wdata = cur_data;

    case (state_q)
      IDLE: begin
        if (cpu_req.valid) begin
          req_d   = cpu_req;
          state_d = COMPARE_TAG;
        end
      end

      COMPARE_TAG: begin
        cpu_res_d.checked = 1'b1;
        if (hit) begin
          // Return the pre-write contents even on a write hit.
          cpu_res_d.ready = 1'b1;
          cpu_res_d.data  = cur_data;
          if (req_q.rw) begin
            line_we          = 1'b1;
            line_wdata       = req_q.data;
            dirty_d[req_idx] = 1'b1;
          end
          state_d = IDLE;
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          mem_req_d.addr  = {cur_tag, req_idx, 2'b00};
          mem_req_d.data  = cur_data;
          mem_req_d.rw    = 1'b1;
          mem_req_d.valid = 1'b1;
          state_d         = WRITE_BACK;
        end else begin
          mem_req_d.addr  = req_q.addr;
          mem_req_d.data  = req_q.data;
          mem_req_d.rw    = 1'b0;
          mem_req_d.valid = 1'b1;
          state_d         = ALLOCATE;
        end
      end

      WRITE_BACK: begin
        if (mem_data.ready) begin
          mem_req_d.addr  = req_q.addr;
          mem_req_d.rw    = 1'b0;
          mem_req_d.valid = 1'b1;
          state_d         = ALLOCATE;
        end
      end

      ALLOCATE: begin
        // Only a ready seen while already here counts; a pulse coinciding
        // with the entry edge was sampled in the previous state.
        if (mem_data.ready) begin
          line_we          = 1'b1;
          valid_d[req_idx] = 1'b1;
          if (req_q.rw) begin
            line_wdata       = req_q.data;
            dirty_d[req_idx] = 1'b1;
          end else begin
            line_wdata       = mem_data.data;
            dirty_d[req_idx] = 1'b0;
          end
          cpu_res_d.ready = 1'b1;
          cpu_res_d.data  = line_wdata;
          mem_req_d.valid = 1'b0;
          mem_req_d.rw    = 1'b0;
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      mem_req_q <= '0;
      cpu_res_q <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      mem_req_q <= mem_req_d;
      cpu_res_q <= cpu_res_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
    end
  end

  // rst gates the write so an aborted fill can never touch the array.
  always_ff @(posedge clk) begin
    if (line_we && !rst) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= line_wdata;
    end
  end

  assign mem_req = mem_req_q;
  assign cpu_res = cpu_res_q;

endmodule

// File: tb/tb_dm_cache_fsm_block.sv
module tb_dm_cache_fsm_block;
  import cache_def::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  cpu_req_type    cpu_req;
  mem_data_type   mem_data;
  mem_req_type    mem_req;
  cpu_result_type cpu_res;

  dm_cache_fsm_block #(.CACHE_BLOCKS(128)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .mem_data (mem_data),
    .mem_req  (mem_req),
    .cpu_res  (cpu_res)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        rw;
    logic        exp_hit;
    logic        exp_wb;
    logic [15:0] wb_addr;
    logic [31:0] wb_data;
    logic [31:0] fill;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: every cpu_res.ready pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (!rst && cpu_res.ready) begin
      if (sb.size() == 0) chk("sb_unexpected_ready", 64'(1), 64'(0));
      else chk("sb_data", 64'(cpu_res.data), 64'(sb.pop_front()));
    end
  end

  task automatic apply_vec(input vec_t v, input int id);
    cpu_req = '{addr: v.addr, data: v.wdata, rw: v.rw, valid: 1'b1};
    sb.push_back(v.exp_rdata);
    tick();
    cpu_req.valid = 1'b0;
    tick();
    $display("txn %0d: %s addr=0x%04h hit=%0b wb=%0b", id, v.rw ? "WR" : "RD", v.addr,
             cpu_res.ready, mem_req.rw);
    chk("checked", 64'(cpu_res.checked), 64'(1));
    chk("hit_ready", 64'(cpu_res.ready), 64'(v.exp_hit));
    chk("memreq_valid", 64'(mem_req.valid), 64'(!v.exp_hit));
    if (v.exp_hit) begin
      tick();
      chk("hit_ready_drop", 64'({cpu_res.ready, cpu_res.checked}), 64'(0));
    end else begin
      chk("memreq_rw", 64'(mem_req.rw), 64'(v.exp_wb));
      chk("memreq_addr", 64'(mem_req.addr), 64'(v.exp_wb ? v.wb_addr : v.addr));
      if (v.exp_wb) chk("wb_data", 64'(mem_req.data), 64'(v.wb_data));
      tick();
      chk("checked_drop", 64'(cpu_res.checked), 64'(0));
      chk("memreq_hold", 64'({mem_req.valid, mem_req.rw}), 64'({1'b1, v.exp_wb}));
      if (v.exp_wb) begin
        mem_data = '{data: 32'h0, ready: 1'b1};
        tick();
        mem_data.ready = 1'b0;
        chk("fill_req", 64'({mem_req.addr, mem_req.rw, mem_req.valid}),
            64'({v.addr, 1'b0, 1'b1}));
        tick();
      end
      mem_data = '{data: v.fill, ready: 1'b1};
      tick();
      mem_data.ready = 1'b0;
      chk("fill_done", 64'({cpu_res.ready, cpu_res.checked, mem_req.valid, mem_req.rw}),
          64'(4'b1000));
      tick();
      chk("fill_ready_drop", 64'(cpu_res.ready), 64'(0));
    end
  endtask

  cpu_result_type res_snap;
  mem_req_type    req_snap;
  vec_t           tv;

  initial begin
    //          addr      wdata         rw   hit  wb   wb_addr   wb_data       fill          exp
    vecs[0] = '{16'h0040, 32'h0,        0,   0,   0,   16'h0,    32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{16'h0040, 32'h0,        0,   1,   0,   16'h0,    32'h0,        32'h0,        32'hDEADBEEF};
    vecs[2] = '{16'h0040, 32'h12345678, 1,   1,   0,   16'h0,    32'h0,        32'h0,        32'hDEADBEEF};
    vecs[3] = '{16'h0240, 32'h0,        0,   0,   1,   16'h0040, 32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[4] = '{16'h0240, 32'h0,        0,   1,   0,   16'h0,    32'h0,        32'h0,        32'hCAFEF00D};
    vecs[5] = '{16'h0100, 32'h000000AA, 1,   0,   0,   16'h0,    32'h0,        32'h55555555, 32'h000000AA};
    vecs[6] = '{16'h0100, 32'h0,        0,   1,   0,   16'h0,    32'h0,        32'h0,        32'h000000AA};
    vecs[7] = '{16'h0300, 32'h0,        0,   0,   1,   16'h0100, 32'h000000AA, 32'h0BADF00D, 32'h0BADF00D};
    vecs[8] = '{16'h0040, 32'h0,        0,   0,   0,   16'h0,    32'h0,        32'h11112222, 32'h11112222};

    cpu_req  = '0;
    mem_data = '0;
    rst      = 1'b1;
    #12;
    chk("reset_outputs", 64'({cpu_res, mem_req} != 0), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

    // Reset during ALLOCATE: outputs clear at once, fill is abandoned.
    cpu_req = '{addr: 16'h0800, data: 32'h0, rw: 1'b0, valid: 1'b1};
    tick();
    cpu_req.valid = 1'b0;
    tick();
    chk("pre_reset_alloc", 64'(mem_req.valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    $display("txn reset-in-allocate: mem_req.valid=%0b", mem_req.valid);
    chk("async_reset_clear", 64'({cpu_res, mem_req} != 0), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tv = '{16'h0040, 32'h0, 0, 0, 0, 16'h0, 32'h0, 32'h77778888, 32'h77778888};
    apply_vec(tv, 100);

    // Ready pulse while IDLE must change nothing.
    res_snap = cpu_res;
    req_snap = mem_req;
    mem_data = '{data: 32'hFFFFFFFF, ready: 1'b1};
    tick();
    mem_data.ready = 1'b0;
    $display("txn idle-ready-pulse");
    chk("idle_ready_res", 64'(cpu_res), 64'(res_snap));
    chk("idle_ready_req", 64'(mem_req), 64'(req_snap));
    tv = '{16'h0040, 32'h0, 0, 1, 0, 16'h0, 32'h0, 32'h0, 32'h77778888};
    apply_vec(tv, 101);

    // Ready during COMPARE_TAG (the edge entering ALLOCATE) must not complete the fill.
    cpu_req = '{addr: 16'h0A00, data: 32'h0, rw: 1'b0, valid: 1'b1};
    sb.push_back(32'h0A0A0A0A);
    tick();
    cpu_req.valid = 1'b0;
    mem_data = '{data: 32'hBAD0BAD0, ready: 1'b1};
    tick();
    mem_data.ready = 1'b0;
    $display("txn entry-edge-ready: ready=%0b memvalid=%0b", cpu_res.ready, mem_req.valid);
    chk("entry_edge_miss", 64'({cpu_res.checked, cpu_res.ready, mem_req.valid}), 64'(3'b101));
    tick();
    chk("entry_edge_ignored", 64'({cpu_res.ready, mem_req.valid}), 64'(2'b01));
    mem_data = '{data: 32'h0A0A0A0A, ready: 1'b1};
    tick();
    mem_data.ready = 1'b0;
    chk("entry_edge_fill", 64'({cpu_res.ready, mem_req.valid}), 64'(2'b10));
    tick();

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_cache_fsm_block.md
DM_CACHE_FSM_BLOCK -- requirements
Module: dm_cache_fsm

Interface
REQ-001 The module SHALL have one parameter, CACHE_BLOCKS, default 128: number of direct-mapped lines, each holding one 32-bit word; it SHALL be a power of two, at least 2.
REQ-002 The struct types SHALL come from package cache_def:
- cpu_req_type: addr[15:0], data[31:0], rw, valid
- mem_req_type: addr[15:0], data[31:0], rw, valid
- mem_data_type: data[31:0], ready
- cpu_result_type: data[31:0], ready, checked
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cpu_req  input  cpu_req_type  processor request; rw=1 means write.
REQ-006 mem_data  input  mem_data_type  memory response; ready is a one-cycle completion pulse.
REQ-007 mem_req  output  mem_req_type  memory request (write-back or line fill).
REQ-008 cpu_res  output  cpu_result_type  lookup result.

Function
REQ-009 Address split SHALL be:
- addr[1:0]: byte offset, ignored.
- index: addr[log2(CACHE_BLOCKS)+1:2].
- tag: the remaining upper address bits.
REQ-010 Each line SHALL hold valid, dirty, tag and data[31:0].
REQ-011 The state machine SHALL have states IDLE, COMPARE_TAG, WRITE_BACK and ALLOCATE, with the following behaviour:
- IDLE: when cpu_req.valid=1, latch the whole cpu_req and go to COMPARE_TAG.
- All other states: ignore cpu_req and use only the latched copy.
REQ-012 COMPARE_TAG SHALL last exactly one cycle, and cpu_res.checked SHALL be 1 in that cycle only. A hit means line valid and stored tag equal to the request tag.
REQ-013 Hit:
- Assert cpu_res.ready=1 and drive cpu_res.data with the line data as it was before any write.
- On a write, store the request data and set dirty=1.
- Go to IDLE.
REQ-014 Miss with a clean or invalid victim:
- mem_req = {addr = request address, rw = 0, valid = 1}.
- Go to ALLOCATE.
REQ-015 Miss with a valid and dirty victim:
- mem_req = {addr = {victim tag, index, 2'b00}, data = victim data, rw = 1, valid = 1}.
- Go to WRITE_BACK.
REQ-016 WRITE_BACK:
- Hold mem_req unchanged.
- On mem_data.ready=1, change mem_req to {addr = request address, rw = 0, valid = 1} and go to ALLOCATE.
REQ-017 ALLOCATE:
- Hold mem_req until mem_data.ready=1 is seen while in this state.
- A ready pulse on the transition edge into ALLOCATE SHALL NOT count.
REQ-018 On completion of ALLOCATE, the line fill SHALL be:
- Line := {valid = 1, tag = request tag}.
- Read: data = mem_data.data, dirty = 0.
- Write: data = request data, dirty = 1.
- Then clear mem_req.valid and mem_req.rw, and go to IDLE.
REQ-019 On that completion edge, cpu_res.ready SHALL pulse high for one cycle with the line data, and cpu_res.checked SHALL be 0.
REQ-020 Output timing:
- cpu_res.ready and cpu_res.checked SHALL be 0 at all times other than those stated.
- mem_req.valid SHALL be 1 only in WRITE_BACK and ALLOCATE.
- Every output SHALL be registered.
REQ-021 Hit latency SHALL be 1 cycle: valid sampled in IDLE at edge N; checked and ready visible after edge N+1.
REQ-022 Back-to-back requests: a request that is still valid in IDLE after a completion SHALL start a new lookup.
REQ-023 mem_data.ready arriving in IDLE or COMPARE_TAG SHALL be ignored.

Reset
REQ-024 While rst=1, the block SHALL immediately and asynchronously go to IDLE, drive all cpu_res and mem_req fields to 0, and clear every line's valid and dirty bits.
REQ-025 A reset in the middle of an operation SHALL abort any write-back or fill with no line update.
REQ-026 The first rising clock edge after rst falls SHALL be able to accept a request.

Verification
REQ-027 The bench SHALL cover these scenarios:
- Cold read after reset, addr 0x0040 -> checked=1, ready=0, mem_req {addr 0x0040, rw 0, valid 1}. Then ready with data 0xDEADBEEF -> line filled, mem_req.valid=0, next state IDLE.
- Re-read of 0x0040 -> after 1 cycle checked=1, ready=1, data=0xDEADBEEF; no mem_req.
- Write 0x12345678 to 0x0040 (hit), then read 0x0240 (same index, different tag) -> mem_req {addr 0x0040, data 0x12345678, rw 1}. After a ready pulse, mem_req {addr 0x0240, rw 0}. After a second ready with 0xCAFEF00D, re-read of 0x0240 hits with 0xCAFEF00D.
- Write miss to 0x0100 with data 0x000000AA -> ALLOCATE. After ready, a read of 0x0100 hits with 0x000000AA. A later conflicting miss on that index writes it back.
- Assert rst during ALLOCATE -> outputs 0 immediately. Then read 0x0040 -> miss.
- mem_data.ready pulsed while in IDLE -> no state or output change.
